conv2d3x3_bn_relu6_q4_param: RTL and testbench
==============================================

# conv2d3x3_bn_relu6_q4_param

Parametrised 3x3 convolution layer engine for the CIFAR-10 edge-AI accelerator. It computes every output channel of a 3x3 conv with batchnorm and ReLU6 requantisation, reading 4-bit activations, 8-bit weights and per-channel BN parameters through external 1-cycle-latency read ports. Results go out as 32-bit packed words, 8 nibbles per word, on a write port. Image size, channel counts and padding mode are generic, so one block serves every conv stage between the pooling layers.

## Interface
- IN_W, 8: input width (>=3)
- IN_H, 8: input height (>=3)
- IN_CH, 64: input channels
- OUT_CH, 128: output channels (filters)
- PAD, 1: 1 = same (zero pad 1, OUT = IN); 0 = valid (OUT_W=IN_W-2, OUT_H=IN_H-2)
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-high reset
- start  in  1  1-cycle request; honoured only in IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  1-cycle pulse at completion
- in_rd  out  1  activation read strobe
- in_addr  out  32  activation index ch*IN_H*IN_W + y*IN_W + x
- in_data  in  4  unsigned activation, valid 1 cycle after in_rd
- w_addr  out  32  weight index f*IN_CH*9 + ch*9 + ky*3 + kx
- w_data  in  8  signed weight, valid 1 cycle after w_addr
- p_addr  out  16  filter index f
- p_data  in  32  {bias[31:24] s8, scale[23:16] s8, shift[15:0] s16}, valid 1 cycle after p_addr
- out_we  out  1  write strobe
- out_addr  out  32  word address n>>3
- out_wdata  out  32  packed word

## Operation
- States: IDLE -> PARAM (2 cycles: issue p_addr, latch p_data) -> MAC (9*IN_CH tap cycles) -> DRAIN (1) -> POST (1) -> MAC for the next pixel, PARAM for the next filter, or DONE (1) -> IDLE.
- Loop order: filter f, output row r, output col c, then ch, ky, kx, innermost last.
- Input position: y = r+ky-PAD, x = c+kx-PAD. If it is out of bounds (PAD=1 only), in_rd=0 and the tap contributes 0 while still taking its cycle.
- Each MAC cycle issues addresses. The data returning 1 cycle later accumulates: acc += $signed({1'b0,in_data}) * w_data. acc is s32 and is cleared at the start of each pixel.
- POST, with all shifts arithmetic:
  - t = sat8((acc + bias) >>> 4)
  - b = sat8((t*scale + shift) >>> 6)
  - q = min((b + 128) / 21, 6)
  - sat8 clamps to [-128, 127].
- Packing:
  - Global index n = f*OUT_H*OUT_W + r*OUT_W + c.
  - Nibble slot n%8 is placed MSB first (slot 0 = [31:28]).
  - The word is written when n%8 == 7 or n is the final output.
  - Unused nibbles of a partial final word are 0.
- The packing register clears after each write and carries across filter boundaries.
- A start during busy is ignored. A reset in any state returns to IDLE within 1 edge and clears acc and the packing register. No write occurs in the cycle reset is high.

## Timing
- Reset values: busy=0, done=0, in_rd=0, out_we=0, in_addr=0, w_addr=0, p_addr=0, out_addr=0, out_wdata=0.
- P = OUT_H*OUT_W. Done goes high exactly C = 2 + OUT_CH*(2 + P*(9*IN_CH+2)) cycles after the edge sampling start.
- out_we is high for exactly 1 cycle, in POST, with out_addr and out_wdata valid in the same cycle.
- Throughput is 1 MAC per cycle and no stalls. Upstream ports must return data in exactly 1 cycle.
- busy falls in the same cycle done rises.

## Test plan
- Same-padding ramp:
  - Setup: IN 4x4, IN_CH=1, OUT_CH=1, PAD=1, all act=6, w=32, bias=0, scale=64, shift=-8192.
  - Expected values: corner 2, edge 3, centre 5.
  - Required writes: word 0x23323553 at addr 0 and word 0x35532332 at addr 1.
  - done at C=180.
- Valid mode: same stimulus with PAD=0 -> 4 outputs of 5, single partial flush 0x55550000 at addr 0, done at C=48.
- Saturation: act=6, w=-128, bias=0, scale=64, shift=0 -> t and b clamp to -128, every nibble is 0.
- Multi-filter packing: OUT_CH=3, OUT_W=OUT_H=3 (27 outputs) -> writes at addr 0..3, last word holds 3 nibbles then zeros. p_addr steps 0,1,2 and w_addr base steps by 9*IN_CH.
- Reset and start abuse:
  - Pulse resetn mid-MAC -> out_we never fires, busy=0 next cycle.
  - Restart -> results identical to an uninterrupted run.
  - start during busy -> no effect.
- Random regression: random IN_CH in 1..8, random tensors, checked against a bit-exact reference model of all writes and done cycle.

Source files
------------

// File: rtl/conv2d3x3_bn_relu6_q4_param.sv
// 3x3 convolution engine with batchnorm and ReLU6 requantisation to 4 bits.
// Walks filter -> output row -> output col -> channel -> ky -> kx, issuing one
// activation/weight read per tap cycle. Each product is accumulated the cycle
// after its address goes out. Finished pixels are packed eight nibbles per
// 32-bit word, most significant slot first.
module conv2d3x3_bn_relu6_q4_param #(
    parameter int IN_W   = 8,
    parameter int IN_H   = 8,
    parameter int IN_CH  = 64,
    parameter int OUT_CH = 128,
    parameter int PAD    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        in_rd,
    output logic [31:0] in_addr,
    input  logic [3:0]  in_data,
    output logic [31:0] w_addr,
    input  logic [7:0]  w_data,
    output logic [15:0] p_addr,
    input  logic [31:0] p_data,
    output logic        out_we,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata
);

    localparam int OUT_W = (PAD != 0) ? IN_W : IN_W - 2;
    localparam int OUT_H = (PAD != 0) ? IN_H : IN_H - 2;

    // S_ARM is a one-cycle launch slot between the start handshake and the
    // first parameter fetch; S_DONE is the closing cycle before the done pulse.
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PARAM0, S_PARAM1, S_MAC, S_DRAIN, S_POST, S_DONE
    } state_t;

    state_t             state_reg;
    logic [31:0]        f_reg, r_reg, c_reg;
    logic [31:0]        ch_reg, ky_reg, kx_reg;
    logic signed [31:0] acc_reg;
    logic               rd_d_reg;
    logic signed [7:0]  bias_reg, scale_reg;
    logic signed [15:0] shift_reg;
    logic [31:0]        pack_reg;
    logic [31:0]        n_reg;
    logic               we_reg;

    logic [31:0]        ch_next, ky_next, kx_next, r_next, c_next;
    logic [31:0]        iss_ch, iss_ky, iss_kx, iss_r, iss_c;
    logic [32:0]        iss_act;
    logic [31:0]        iss_w;
    logic               tap_last, pix_last, filt_last;

    logic signed [12:0] prod;
    logic signed [31:0] acc_sum, pre_t, pre_b;
    logic signed [7:0]  t_val, b_val;
    logic [7:0]         b_off;
    logic [3:0]         q_val;
    logic [31:0]        pack_next;

    // Clamp a signed 32-bit value into the signed 8-bit range.
    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)
            sat8 = 8'sd127;
        else if (v < -32'sd128)
            sat8 = -8'sd128;
        else
            sat8 = 8'(v);
    endfunction

    // Activation index for a tap; bit 32 flags an in-bounds position.
    function automatic logic [32:0] act_index(input logic [31:0] ch, input logic [31:0] ky,
                                              input logic [31:0] kx, input logic [31:0] r,
                                              input logic [31:0] c);
        int y;
        int x;
        y = int'(r) + int'(ky) - PAD;
        x = int'(c) + int'(kx) - PAD;
        if (y < 0 || y >= IN_H || x < 0 || x >= IN_W)
            act_index = 33'd0;
        else
            act_index = {1'b1, ch * 32'(IN_H * IN_W) + 32'(y * IN_W + x)};
    endfunction

    // Weight index for a tap of filter f.
    function automatic logic [31:0] w_index(input logic [31:0] f, input logic [31:0] ch,
                                            input logic [31:0] ky, input logic [31:0] kx);
        w_index = f * 32'(IN_CH * 9) + ch * 32'd9 + ky * 32'd3 + kx;
    endfunction

    // Next tap within the pixel and next pixel within the filter.
    always_comb begin
        kx_next = kx_reg + 32'd1;
        ky_next = ky_reg;
        ch_next = ch_reg;
        if (kx_reg == 32'd2) begin
            kx_next = 32'd0;
            ky_next = ky_reg + 32'd1;
            if (ky_reg == 32'd2) begin
                ky_next = 32'd0;
                ch_next = ch_reg + 32'd1;
            end
        end
        c_next = c_reg + 32'd1;
        r_next = r_reg;
        if (c_reg == 32'(OUT_W - 1)) begin
            c_next = 32'd0;
            r_next = r_reg + 32'd1;
        end
        tap_last  = (ch_reg == 32'(IN_CH - 1)) && (ky_reg == 32'd2) && (kx_reg == 32'd2);
        pix_last  = (r_reg == 32'(OUT_H - 1)) && (c_reg == 32'(OUT_W - 1));
        filt_last = (f_reg == 32'(OUT_CH - 1));
    end

    // Select which tap gets its addresses registered at the coming edge.
    always_comb begin
        iss_ch = 32'd0;
        iss_ky = 32'd0;
        iss_kx = 32'd0;
        iss_r  = r_reg;
        iss_c  = c_reg;
        if (state_reg == S_MAC) begin
            iss_ch = ch_next;
            iss_ky = ky_next;
            iss_kx = kx_next;
        end else if (state_reg == S_POST) begin
            iss_r = r_next;
            iss_c = c_next;
        end
        iss_act = act_index(iss_ch, iss_ky, iss_kx, iss_r, iss_c);
        iss_w   = w_index(f_reg, iss_ch, iss_ky, iss_kx);
    end

    // Accumulate the returning tap and requantise the finished sum.
    always_comb begin
        prod    = $signed({1'b0, in_data}) * $signed(w_data);
        acc_sum = acc_reg + (rd_d_reg ? 32'(prod) : 32'sd0);
        pre_t   = acc_sum + 32'(bias_reg);
        t_val   = sat8(pre_t >>> 4);
        pre_b   = 32'(t_val) * 32'(scale_reg) + 32'(shift_reg);
        b_val   = sat8(pre_b >>> 6);
        b_off   = {~b_val[7], b_val[6:0]};
        q_val   = (b_off >= 8'd126) ? 4'd6 : 4'(b_off / 8'd21);
    end

    // Drop the new nibble into its slot, MSB-first.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            assign pack_next[31-4*gi -: 4] = (n_reg[2:0] == 3'(gi)) ? q_val
                                                                    : pack_reg[31-4*gi -: 4];
        end
    endgenerate

    // A write never escapes while reset is being applied.
    assign out_we = we_reg & ~resetn;

    // Control FSM, address generation, accumulator and output packing.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_rd     <= 1'b0;
            in_addr   <= 32'd0;
            w_addr    <= 32'd0;
            p_addr    <= 16'd0;
            out_addr  <= 32'd0;
            out_wdata <= 32'd0;
            we_reg    <= 1'b0;
            f_reg     <= 32'd0;
            r_reg     <= 32'd0;
            c_reg     <= 32'd0;
            ch_reg    <= 32'd0;
            ky_reg    <= 32'd0;
            kx_reg    <= 32'd0;
            acc_reg   <= 32'sd0;
            rd_d_reg  <= 1'b0;
            bias_reg  <= 8'sd0;
            scale_reg <= 8'sd0;
            shift_reg <= 16'sd0;
            pack_reg  <= 32'd0;
            n_reg     <= 32'd0;
        end else begin
            done     <= 1'b0;
            we_reg   <= 1'b0;
            rd_d_reg <= in_rd;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        state_reg <= S_ARM;
                    end
                end
                S_ARM: begin
                    f_reg     <= 32'd0;
                    r_reg     <= 32'd0;
                    c_reg     <= 32'd0;
                    n_reg     <= 32'd0;
                    pack_reg  <= 32'd0;
                    acc_reg   <= 32'sd0;
                    p_addr    <= 16'd0;
                    state_reg <= S_PARAM0;
                end
                S_PARAM0: begin
                    state_reg <= S_PARAM1;
                end
                S_PARAM1: begin
                    bias_reg  <= p_data[31:24];
                    scale_reg <= p_data[23:16];
                    shift_reg <= p_data[15:0];
                    ch_reg    <= 32'd0;
                    ky_reg    <= 32'd0;
                    kx_reg    <= 32'd0;
                    in_rd     <= iss_act[32];
                    in_addr   <= iss_act[31:0];
                    w_addr    <= iss_w;
                    acc_reg   <= 32'sd0;
                    state_reg <= S_MAC;
                end
                S_MAC: begin
                    acc_reg <= acc_sum;
                    if (tap_last) begin
                        in_rd     <= 1'b0;
                        state_reg <= S_DRAIN;
                    end else begin
                        ch_reg  <= ch_next;
                        ky_reg  <= ky_next;
                        kx_reg  <= kx_next;
                        in_rd   <= iss_act[32];
                        in_addr <= iss_act[31:0];
                        w_addr  <= iss_w;
                    end
                end
                S_DRAIN: begin
                    acc_reg <= 32'sd0;
                    n_reg   <= n_reg + 32'd1;
                    if (n_reg[2:0] == 3'd7 || (filt_last && pix_last)) begin
                        we_reg    <= 1'b1;
                        out_addr  <= n_reg >> 3;
                        out_wdata <= pack_next;
                        pack_reg  <= 32'd0;
                    end else begin
                        pack_reg <= pack_next;
                    end
                    state_reg <= S_POST;
                end
                S_POST: begin
                    if (pix_last) begin
                        if (filt_last) begin
                            state_reg <= S_DONE;
                        end else begin
                            f_reg     <= f_reg + 32'd1;
                            r_reg     <= 32'd0;
                            c_reg     <= 32'd0;
                            p_addr    <= 16'(f_reg + 32'd1);
                            state_reg <= S_PARAM0;
                        end
                    end else begin
                        r_reg     <= r_next;
                        c_reg     <= c_next;
                        ch_reg    <= 32'd0;
                        ky_reg    <= 32'd0;
                        kx_reg    <= 32'd0;
                        in_rd     <= iss_act[32];
                        in_addr   <= iss_act[31:0];
                        w_addr    <= iss_w;
                        state_reg <= S_MAC;
                    end
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d3x3_bn_relu6_q4_param.sv
// Bench for the 3x3 conv engine: one same-padding and one valid-padding
// instance run side by side against a loop-level reference model.
module tb_conv2d3x3_bn_relu6_q4_param;

    localparam int W0 = 4, H0 = 4, CH0 = 2, OC0 = 3, PAD0 = 1;
    localparam int W1 = 5, H1 = 5, CH1 = 1, OC1 = 3, PAD1 = 0;
    localparam int P0 = 16, P1 = 9;
    localparam int C0 = 2 + OC0 * (2 + P0 * (9 * CH0 + 2));
    localparam int C1 = 2 + OC1 * (2 + P1 * (9 * CH1 + 2));

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        busy0, busy1, done0, done1, in_rd0, in_rd1, out_we0, out_we1;
    logic [31:0] in_addr0, in_addr1, w_addr0, w_addr1;
    logic [31:0] out_addr0, out_addr1, out_wdata0, out_wdata1;
    logic [15:0] p_addr0, p_addr1;
    logic [3:0]  in_data0, in_data1;
    logic [7:0]  w_data0, w_data1;
    logic [31:0] p_data0, p_data1;

    logic [3:0]  act_m [2][64];
    logic [7:0]  wgt_m [2][64];
    logic [31:0] par_m [2][4];

    logic [31:0] exp_a [2][16];
    logic [31:0] exp_d [2][16];
    int          exp_n [2];
    logic [31:0] got_a [2][16];
    logic [31:0] got_d [2][16];
    int          got_n [2];
    int          dc [2];
    logic        bz [2];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d3x3_bn_relu6_q4_param #(.IN_W(W0), .IN_H(H0), .IN_CH(CH0), .OUT_CH(OC0), .PAD(PAD0)) dut0 (
        .clk(clk), .resetn(resetn), .start(start0), .busy(busy0), .done(done0),
        .in_rd(in_rd0), .in_addr(in_addr0), .in_data(in_data0),
        .w_addr(w_addr0), .w_data(w_data0), .p_addr(p_addr0), .p_data(p_data0),
        .out_we(out_we0), .out_addr(out_addr0), .out_wdata(out_wdata0));

    conv2d3x3_bn_relu6_q4_param #(.IN_W(W1), .IN_H(H1), .IN_CH(CH1), .OUT_CH(OC1), .PAD(PAD1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .busy(busy1), .done(done1),
        .in_rd(in_rd1), .in_addr(in_addr1), .in_data(in_data1),
        .w_addr(w_addr1), .w_data(w_data1), .p_addr(p_addr1), .p_data(p_data1),
        .out_we(out_we1), .out_addr(out_addr1), .out_wdata(out_wdata1));

    // One-cycle-latency memories behind both instances.
    always @(posedge clk) begin
        in_data0 <= act_m[0][in_addr0 % 32'd64];
        w_data0  <= wgt_m[0][w_addr0 % 32'd64];
        p_data0  <= par_m[0][p_addr0 % 16'd4];
        in_data1 <= act_m[1][in_addr1 % 32'd64];
        w_data1  <= wgt_m[1][w_addr1 % 32'd64];
        p_data1  <= par_m[1][p_addr1 % 16'd4];
    end

    // Capture writes and the done edge away from the active edge.
    always @(negedge clk) begin
        if (out_we0 && got_n[0] < 16) begin
            got_a[0][got_n[0]] = out_addr0;
            got_d[0][got_n[0]] = out_wdata0;
            got_n[0]++;
        end
        if (out_we1 && got_n[1] < 16) begin
            got_a[1][got_n[1]] = out_addr1;
            got_d[1][got_n[1]] = out_wdata1;
            got_n[1]++;
        end
        if (done0 && dc[0] < 0) begin dc[0] = cyc; bz[0] = busy0; end
        if (done1 && dc[1] < 0) begin dc[1] = cyc; bz[1] = busy1; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Straight loop nest over the convolution, then requantise and pack.
    task automatic model(input int s, input int iw, input int ih, input int ich,
                         input int och, input int pad);
        int ow, oh, tot, n, word, acc, t, b, q, y, x, bias, scale, shift;
        ow = pad ? iw : iw - 2;
        oh = pad ? ih : ih - 2;
        tot = och * oh * ow;
        n = 0;
        word = 0;
        exp_n[s] = 0;
        for (int f = 0; f < och; f++)
            for (int r = 0; r < oh; r++)
                for (int c = 0; c < ow; c++) begin
                    acc = 0;
                    for (int ch = 0; ch < ich; ch++)
                        for (int ky = 0; ky < 3; ky++)
                            for (int kx = 0; kx < 3; kx++) begin
                                y = r + ky - pad;
                                x = c + kx - pad;
                                if (y >= 0 && y < ih && x >= 0 && x < iw)
                                    acc += int'(act_m[s][ch*ih*iw + y*iw + x]) *
                                           int'($signed(wgt_m[s][f*ich*9 + ch*9 + ky*3 + kx]));
                            end
                    bias  = int'($signed(par_m[s][f][31:24]));
                    scale = int'($signed(par_m[s][f][23:16]));
                    shift = int'($signed(par_m[s][f][15:0]));
                    t = sat8((acc + bias) >>> 4);
                    b = sat8((t * scale + shift) >>> 6);
                    q = (b + 128) / 21;
                    if (q > 6) q = 6;
                    word = word | (q << (28 - 4 * (n % 8)));
                    if (n % 8 == 7 || n == tot - 1) begin
                        exp_a[s][exp_n[s]] = 32'(n / 8);
                        exp_d[s][exp_n[s]] = 32'(word);
                        exp_n[s]++;
                        word = 0;
                    end
                    n++;
                end
    endtask

    task automatic load_random();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                act_m[s][i] = 4'($urandom_range(0, 15));
                wgt_m[s][i] = 8'($urandom_range(0, 255));
            end
            for (int i = 0; i < 4; i++)
                par_m[s][i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                               16'($urandom_range(0, 65535))};
        end
    endtask

    task automatic load_directed();
        load_random();
        for (int i = 0; i < 16; i++) act_m[0][i] = 4'd6;
        for (int i = 0; i < 18; i++) wgt_m[0][i] = (i < 9) ? 8'd32 : 8'd0;
        par_m[0][0] = {8'd0, 8'd64, 16'hE000};
        for (int i = 0; i < 25; i++) act_m[1][i] = 4'd6;
        for (int i = 0; i < 27; i++) wgt_m[1][i] = (i < 18) ? 8'd32 : 8'h80;
        par_m[1][0] = {8'd0, 8'd64, 16'hE000};
        par_m[1][1] = {8'd0, 8'd64, 16'hE000};
        par_m[1][2] = {8'd0, 8'd64, 16'h0000};
    endtask

    task automatic run_pair(input string name, input bit abuse);
        int t0;
        got_n[0] = 0; got_n[1] = 0;
        dc[0] = -1;   dc[1] = -1;
        model(0, W0, H0, CH0, OC0, PAD0);
        model(1, W1, H1, CH1, OC1, PAD1);
        @(negedge clk);
        start0 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start0 = 1'b0; start1 = 1'b0;
        check({name, "_busy0"}, 32'(busy0), 32'd1);
        check({name, "_busy1"}, 32'(busy1), 32'd1);
        if (abuse) begin
            repeat (25) @(negedge clk);
            start0 = 1'b1; start1 = 1'b1;
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0;
        end
        for (int i = 0; i < 4000 && (dc[0] < 0 || dc[1] < 0); i++) @(negedge clk);
        check({name, "_done_c0"}, 32'(dc[0] - t0), 32'(C0));
        check({name, "_done_c1"}, 32'(dc[1] - t0), 32'(C1));
        check({name, "_busy_at_done0"}, 32'(bz[0]), 32'd0);
        check({name, "_busy_at_done1"}, 32'(bz[1]), 32'd0);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s_nwr%0d", name, s), 32'(got_n[s]), 32'(exp_n[s]));
            for (int i = 0; i < exp_n[s] && i < got_n[s]; i++) begin
                check($sformatf("%s_addr%0d_%0d", name, s, i), got_a[s][i], exp_a[s][i]);
                check($sformatf("%s_data%0d_%0d", name, s, i), got_d[s][i], exp_d[s][i]);
            end
        end
        $display("run %s: writes=%0d/%0d done_after=%0d/%0d", name, got_n[0], got_n[1],
                 dc[0] - t0, dc[1] - t0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n_before;
        got_n[0] = 0; got_n[1] = 0;
        dc[0] = -1;   dc[1] = -1;
        load_random();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_in_rd", 32'(in_rd0), 32'd0);
        check("rst_out_we", 32'(out_we0), 32'd0);
        check("rst_in_addr", in_addr0, 32'd0);
        check("rst_w_addr", w_addr0, 32'd0);
        check("rst_p_addr", 32'(p_addr0), 32'd0);
        check("rst_out_addr", out_addr0, 32'd0);
        check("rst_out_wdata", out_wdata0, 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_out_wdata1", out_wdata1, 32'd0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp, valid-mode and saturation patterns with known answers.
        load_directed();
        run_pair("directed", 1'b0);
        check("ramp_w0", got_d[0][0], 32'h23323553);
        check("ramp_w1", got_d[0][1], 32'h35532332);
        check("valid_w0", got_d[1][0], 32'h55555555);
        check("sat_w2", got_d[1][2], 32'h55000000);
        check("sat_w3", got_d[1][3], 32'h00000000);
        check("pack_last_addr", got_a[1][3], 32'd3);

        // A second start while busy must change nothing.
        load_random();
        run_pair("start_abuse", 1'b1);

        // Reset in the middle of MAC, then a clean rerun of the same tensors.
        load_random();
        @(negedge clk);
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        repeat (30) @(negedge clk);
        n_before = got_n[0] + got_n[1];
        resetn = 1'b1;
        #1;
        check("rst_mid_we0", 32'(out_we0), 32'd0);
        check("rst_mid_we1", 32'(out_we1), 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        check("rst_mid_busy0", 32'(busy0), 32'd0);
        check("rst_mid_busy1", 32'(busy1), 32'd0);
        check("rst_mid_in_rd", 32'(in_rd0), 32'd0);
        repeat (20) @(negedge clk);
        check("rst_mid_nowrite", 32'(got_n[0] + got_n[1]), 32'(n_before));
        run_pair("restart", 1'b0);

        for (int k = 0; k < 3; k++) begin
            load_random();
            run_pair($sformatf("random%0d", k), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
